// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with register-window select.
// Optional macro ILLEGAL_TRAP_EN: opcodes 19-31 enter TRAP and set a sticky illegal flag.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [4:0] alu_op,
    output logic       alu_src_b,
    output logic       reg_write,
    output logic       reg_src,
    output logic [1:0] wnd,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [4:0] OpLoad  = 5'd0;
    localparam logic [4:0] OpStore = 5'd1;
    localparam logic [4:0] OpJump  = 5'd2;
    localparam logic [4:0] OpBrz   = 5'd3;
    localparam logic [4:0] OpMove  = 5'd4;
    localparam logic [4:0] OpAdd   = 5'd5;
    localparam logic [4:0] OpSub   = 5'd6;
    localparam logic [4:0] OpAnd   = 5'd7;
    localparam logic [4:0] OpOr    = 5'd8;
    localparam logic [4:0] OpNot   = 5'd9;
    localparam logic [4:0] OpNop   = 5'd10;
    localparam logic [4:0] OpWnd0  = 5'd11;
    localparam logic [4:0] OpWnd3  = 5'd14;
    localparam logic [4:0] OpAddi  = 5'd15;
    localparam logic [4:0] OpSubi  = 5'd16;
    localparam logic [4:0] OpAndi  = 5'd17;
    localparam logic [4:0] OpOri   = 5'd18;

    state_e     r_state;
    logic [1:0] r_wnd;

    logic w_is_mem;
    logic w_is_wnd;
    logic w_is_reg_alu;
    logic w_is_imm_alu;
    logic w_is_bad;
    logic w_is_skip;

    assign w_is_mem     = (opcode == OpLoad) || (opcode == OpStore);
    assign w_is_wnd     = (opcode >= OpWnd0) && (opcode <= OpWnd3);
    assign w_is_reg_alu = (opcode >= OpMove) && (opcode <= OpNot);
    assign w_is_imm_alu = (opcode >= OpAddi) && (opcode <= OpOri);
    assign w_is_bad     = (opcode > OpOri);
    // Instructions that finish in DECODE and return straight to FETCH
    assign w_is_skip    = (opcode == OpNop) || (opcode == OpJump) || w_is_wnd;

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StFetch;
            r_wnd     <= 2'd0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                StFetch: begin
                    if (mem_ack) begin
                        r_state <= StDecode;
                    end
                end
                StDecode: begin
                    if (w_is_bad) begin
`ifdef ILLEGAL_TRAP_EN
                        r_state   <= StTrap;
                        r_illegal <= 1'b1;
`else
                        r_state   <= StFetch;
`endif
                    end else if (w_is_skip) begin
                        r_state <= StFetch;
                        if (w_is_wnd) begin
                            // WND0..3 = 11..14, low bits 3,0,1,2 map to 0..3
                            r_wnd <= opcode[1:0] + 2'd1;
                        end
                    end else begin
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    r_state <= w_is_mem ? StMem : StWb;
                end
                StMem: begin
                    if (mem_ack) begin
                        r_state <= (opcode == OpStore) ? StFetch : StWb;
                    end
                end
                StWb: begin
                    r_state <= StFetch;
                end
                StTrap: begin
`ifdef ILLEGAL_TRAP_EN
                    r_state <= StTrap;
`else
                    r_state <= StFetch;
`endif
                end
                default: begin
                    r_state <= StFetch;
                end
            endcase
        end
    end

    // Strobes are gated by rst so nothing is requested while reset is held
    always_comb begin
        mem_req   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_op    = 5'd0;
        alu_src_b = 1'b0;
        reg_write = 1'b0;
        reg_src   = 1'b0;
        if (rst) begin
            case (r_state)
                StFetch: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 2'd0;
                    end
                end
                StDecode: begin
                    if (opcode == OpJump) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd1;
                    end
                end
                StExec: begin
                    if (opcode >= OpBrz && opcode <= OpNot) begin
                        alu_op = opcode;
                    end else begin
                        case (opcode)
                            OpAddi:  begin alu_op = OpAdd; alu_src_b = 1'b1; end
                            OpSubi:  begin alu_op = OpSub; alu_src_b = 1'b1; end
                            OpAndi:  begin alu_op = OpAnd; alu_src_b = 1'b1; end
                            OpOri:   begin alu_op = OpOr;  alu_src_b = 1'b1; end
                            OpLoad,
                            OpStore: begin alu_op = OpAdd; alu_src_b = 1'b1; end
                            default: begin alu_op = 5'd0;  alu_src_b = 1'b0; end
                        endcase
                    end
                end
                StMem: begin
                    mem_req   = 1'b1;
                    mem_read  = (opcode == OpLoad);
                    mem_write = (opcode == OpStore);
                end
                StWb: begin
                    if (opcode == OpBrz) begin
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                        end
                    end else if (opcode == OpLoad) begin
                        reg_write = 1'b1;
                        reg_src   = 1'b1;
                    end else if (w_is_reg_alu || w_is_imm_alu) begin
                        reg_write = 1'b1;
                        reg_src   = 1'b0;
                    end
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

    assign wnd   = r_wnd;
    assign state = r_state;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have the port opcode, input, 5 bits: current instruction opcode from IR, with LOAD=0 STORE=1 JUMP=2 BRANCH_Z=3 MOVE=4 ADD=5 SUB=6 AND=7 OR=8 NOT=9 NOP=10 WND0..3=11..14 ADDI=15 SUBI=16 ANDI=17 ORI=18.
REQ-004 The module SHALL have the port zero, input, 1 bit: ALU Zero flag, registered in the ALU, valid the cycle after EXEC.
REQ-005 The module SHALL have the port mem_ack, input, 1 bit: memory completion strobe for the current mem_req.
REQ-006 The module SHALL have the port mem_req, output, 1 bit: memory access request, held until mem_ack.
REQ-007 The module SHALL have the ports mem_read / mem_write, output, 1 bit each: access direction, valid while mem_req=1.
REQ-008 The module SHALL have the port ir_write, output, 1 bit: load IR from memory data.
REQ-009 The module SHALL have the port pc_write, output, 1 bit: update PC.
REQ-010 The module SHALL have the port pc_src, output, 2 bits: 0=PC+1, 1=jump target, 2=branch target.
REQ-011 The module SHALL have the port alu_op, output, 5 bits: operation code to ALU.
REQ-012 The module SHALL have the port alu_src_b, output, 1 bit: 0=register B, 1=immediate.
REQ-013 The module SHALL have the port reg_write, output, 1 bit: register-file write enable.
REQ-014 The module SHALL have the port reg_src, output, 1 bit: 0=ALU out, 1=memory data.
REQ-015 The module SHALL have the port wnd, output, 2 bits: current register window.
REQ-016 The module SHALL have the port state, output, 3 bits: FSM state, for debug.
REQ-017 The module SHALL have the port illegal, output, 1 bit: sticky illegal-opcode flag (ILLEGAL_TRAP_EN only; otherwise tied 0).

Function
REQ-018 The FSM SHALL use the state encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; encodings 6-7 SHALL go to FETCH on the next cycle.
REQ-019 All outputs SHALL be combinational from state and inputs except wnd and illegal, which are registered; outputs not named for a state SHALL be 0.
REQ-020 In FETCH, the block SHALL assert mem_req=1 and mem_read=1; on mem_ack=1 it SHALL assert ir_write=1 and pc_write=1 with pc_src=0, then go to DECODE; otherwise it SHALL stay in FETCH.
REQ-021 In DECODE, NOP SHALL go to FETCH.
REQ-022 In DECODE, JUMP SHALL assert pc_write=1 with pc_src=1, then go to FETCH.
REQ-023 In DECODE, WNDn SHALL load wnd<=n at the clock edge, then go to FETCH.
REQ-024 In DECODE, all other legal opcodes SHALL go to EXEC.
REQ-025 In EXEC, the block SHALL drive alu_op=opcode for opcodes 3-9.
REQ-026 In EXEC, ADDI/SUBI/ANDI/ORI SHALL drive alu_op=ADD/SUB/AND/OR with alu_src_b=1.
REQ-027 In EXEC, LOAD/STORE SHALL drive alu_op=ADD with alu_src_b=1 to form the address.
REQ-028 EXEC SHALL last exactly 1 cycle; LOAD/STORE SHALL then go to MEM and all others to WB.
REQ-029 In MEM, the block SHALL assert mem_req=1, with mem_write=1 for STORE and mem_read=1 for LOAD; on mem_ack, STORE SHALL go to FETCH and LOAD to WB; otherwise it SHALL stay in MEM.
REQ-030 In WB, BRANCH_Z SHALL assert pc_write=1 with pc_src=2 only if zero=1, and SHALL assert reg_write=0.
REQ-031 In WB, LOAD SHALL assert reg_write=1 with reg_src=1.
REQ-032 In WB, ALU operations SHALL assert reg_write=1 with reg_src=0.
REQ-033 WB SHALL always go to FETCH.
REQ-034 Instruction latency with zero-wait memory SHALL be: NOP/JUMP/WND 2 cycles, ALU/branch 4 cycles, STORE 4 cycles, LOAD 5 cycles; each mem_ack wait adds 1 cycle.
REQ-035 A mem_ack arriving outside FETCH/MEM SHALL be ignored.
REQ-036 The opcode input SHALL be sampled every cycle; the IR is stable from DECODE to the end of the instruction.

Reset
REQ-037 rst=0 SHALL force state=FETCH, wnd=0 and illegal=0 immediately, independent of clk.
REQ-038 During reset, all strobes SHALL be 0, including mem_req.
REQ-039 Deassertion of rst SHALL take effect at the next clk edge; the first FETCH SHALL then begin.
REQ-040 Reset mid-access SHALL abandon the access; no pc_write or reg_write for it SHALL occur.

Configuration
REQ-041 With ILLEGAL_TRAP_EN defined, DECODE of an opcode from 19 to 31 SHALL go to TRAP and set illegal=1; TRAP SHALL hold with all strobes 0 until reset.
REQ-042 Without ILLEGAL_TRAP_EN, opcodes 19-31 SHALL be treated as NOP, the TRAP state SHALL be unreachable, and illegal SHALL be 0.

Verification
REQ-043 Reset with mem_ack=1, opcode=ADD, then release -> state trace 0,1,2,4,0; alu_op=5 in EXEC; reg_write=1 and reg_src=0 in WB only.
REQ-044 LOAD with mem_ack delayed 3 cycles in MEM -> MEM held 3 extra cycles with mem_req=mem_read=1; then WB with reg_write=1 and reg_src=1.
REQ-045 BRANCH_Z with zero=1, then with zero=0 -> pc_write=1 and pc_src=2 in WB for the first case; no pc_write in WB for the second.
REQ-046 WND2 then ORI -> wnd=2 after DECODE; in EXEC alu_op=8 and alu_src_b=1.
REQ-047 rst asserted while in MEM for STORE -> state=0 without waiting for a clock edge; no mem_write after rst=0.
REQ-048 With ILLEGAL_TRAP_EN defined, opcode=25 -> TRAP, illegal=1, strobes 0 for 10+ cycles. Without ILLEGAL_TRAP_EN, opcode=25 -> 0,1,0 trace.
